// File: rtl/lcd12864_text_feeder.sv
// Text-buffer front end for the ST7920 LCD12864 bus writer: holds a 4x16 character
// buffer and streams init commands, then dirty rows, as {rs, byte} valid/ready beats.
module lcd12864_text_feeder #(
  parameter logic [15:0] CLR_GAP   = 16'd2000,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  output logic       out_valid,
  output logic       out_rs,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_INIT = 3'd1,
    S_GAP  = 3'd2,
    S_IDLE = 3'd3,
    S_ADDR = 3'd4,
    S_DATA = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [5:0]  fill_cnt, fill_cnt_nx;
  logic [1:0]  init_idx, init_nx;
  logic [15:0] gap_cnt, gap_nx;
  logic [1:0]  row, row_nx;
  logic [3:0]  col, col_nx;
  logic [3:0]  dirty, dirty_nx;
  logic [7:0]  mem [0:63];

  logic        fire, host_wr, clr_row;
  logic [3:0]  set_mask, pending;
  logic        load, load_rs, load_mem;
  logic [7:0]  load_cmd, load_byte;
  logic [5:0]  load_addr;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h30;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] row_cmd(input logic [1:0] r);
    case (r)
      2'd0:    row_cmd = 8'h80;
      2'd1:    row_cmd = 8'h90;
      2'd2:    row_cmd = 8'h88;
      default: row_cmd = 8'h98;
    endcase
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] p);
    if (p[0])      lowest = 2'd0;
    else if (p[1]) lowest = 2'd1;
    else if (p[2]) lowest = 2'd2;
    else           lowest = 2'd3;
  endfunction

  assign fire    = out_valid & out_ready;
  assign host_wr = wr_en & (state != S_FILL);
  assign busy    = !((state == S_IDLE) && (dirty == 4'd0));

  always_comb begin
    set_mask = 4'd0;
    if (host_wr)
      set_mask[wr_addr[5:4]] = 1'b1;
    if (refresh && (state != S_FILL))
      set_mask = 4'hF;
  end

  // Row choice also sees a mark landing this cycle, so a lower row written
  // right after a higher one still goes first.
  assign pending = dirty | set_mask;

  always_comb begin
    state_nx    = state;
    fill_cnt_nx = fill_cnt;
    init_nx     = init_idx;
    gap_nx      = gap_cnt;
    row_nx      = row;
    col_nx      = col;
    clr_row     = 1'b0;
    load        = 1'b0;
    load_rs     = 1'b0;
    load_mem    = 1'b0;
    load_cmd    = 8'h00;
    load_addr   = {row, col};
    case (state)
      S_FILL: begin
        fill_cnt_nx = fill_cnt + 6'd1;
        if (fill_cnt == 6'd63) begin
          state_nx = S_INIT;
          init_nx  = 2'd0;
          load     = 1'b1;
          load_cmd = init_cmd(2'd0);
        end
      end
      S_INIT: begin
        if (fire) begin
          if (init_idx == 2'd3) begin
            state_nx = S_GAP;
            gap_nx   = 16'd0;
          end else begin
            init_nx  = init_idx + 2'd1;
            load     = 1'b1;
            load_cmd = init_cmd(init_idx + 2'd1);
          end
        end
      end
      // The IDLE cycle that follows is the last of the CLR_GAP quiet cycles.
      S_GAP: begin
        if (({1'b0, gap_cnt} + 17'd2) >= {1'b0, CLR_GAP})
          state_nx = S_IDLE;
        else
          gap_nx = gap_cnt + 16'd1;
      end
      S_IDLE: begin
        if (dirty != 4'd0) begin
          row_nx   = lowest(pending);
          state_nx = S_ADDR;
          load     = 1'b1;
          load_cmd = row_cmd(lowest(pending));
        end
      end
      S_ADDR: begin
        if (fire) begin
          clr_row   = 1'b1;
          col_nx    = 4'd0;
          state_nx  = S_DATA;
          load      = 1'b1;
          load_rs   = 1'b1;
          load_mem  = 1'b1;
          load_addr = {row, 4'd0};
        end
      end
      S_DATA: begin
        if (fire) begin
          if (col == 4'd15) begin
            state_nx = S_IDLE;
          end else begin
            col_nx    = col + 4'd1;
            load      = 1'b1;
            load_rs   = 1'b1;
            load_mem  = 1'b1;
            load_addr = {row, col + 4'd1};
          end
        end
      end
      default: begin
        state_nx    = S_FILL;
        fill_cnt_nx = 6'd0;
      end
    endcase
  end

  always_comb begin
    dirty_nx = dirty;
    if (clr_row)
      dirty_nx[row] = 1'b0;
    dirty_nx = dirty_nx | set_mask;
    if (state == S_FILL)
      dirty_nx = 4'hF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      fill_cnt <= 6'd0;
      init_idx <= 2'd0;
      gap_cnt  <= 16'd0;
      row      <= 2'd0;
      col      <= 4'd0;
      dirty    <= 4'hF;
    end else begin
      state    <= state_nx;
      fill_cnt <= fill_cnt_nx;
      init_idx <= init_nx;
      gap_cnt  <= gap_nx;
      row      <= row_nx;
      col      <= col_nx;
      dirty    <= dirty_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_FILL)
      mem[fill_cnt] <= FILL_CHAR;
    else if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // out_data doubles as the buffer's read register; a same-cycle host write is forwarded.
  assign load_byte = (host_wr && (wr_addr == load_addr)) ? wr_data : mem[load_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rs    <= 1'b0;
      out_data  <= 8'h00;
    end else if (load) begin
      out_valid <= 1'b1;
      out_rs    <= load_rs;
      out_data  <= load_mem ? load_byte : load_cmd;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
